// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------
// alarm_pkg : key status codes and state encodings for the alarm
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package alarm_pkg;

  localparam logic [1:0] KEY_OK    = 2'd0;
  localparam logic [1:0] KEY_ERROR = 2'd2;
  localparam logic [1:0] KEY_NOKEY = 2'd3;

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4,
    ST_LOCKOUT     = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/key_event_sync.sv
// ---------------------------------------------------------------
// key_event_sync : synchronizes key status, emits NOKEY->OK/ERROR pulses
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module key_event_sync
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] key_status,
  output logic       ok_ev,
  output logic       err_ev
);

  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_s3;
  logic [1:0] r_last;
  logic       w_stable;
  logic       w_from_nokey;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= KEY_NOKEY;
      r_s2   <= KEY_NOKEY;
      r_s3   <= KEY_NOKEY;
      r_last <= KEY_NOKEY;
    end else begin
      r_s1 <= key_status;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      // r_last only follows settled values, so one-sample glitches never reach it
      if (w_stable) begin
        r_last <= r_s3;
      end
    end
  end

  assign w_stable     = (r_s2 == r_s3);
  assign w_from_nokey = w_stable && (r_last == KEY_NOKEY);
  assign ok_ev        = w_from_nokey && (r_s3 == KEY_OK);
  assign err_ev       = w_from_nokey && (r_s3 == KEY_ERROR);

endmodule

`default_nettype wire

// File: rtl/alarm_controller.sv
// ---------------------------------------------------------------
// alarm_controller : home-alarm FSM with shared timer and error lockout
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module alarm_controller
  import alarm_pkg::*;
#(
  parameter int EXIT_CYC    = 8,
  parameter int ENTRY_CYC   = 6,
  parameter int ALARM_CYC   = 10,
  parameter int LOCKOUT_CYC = 12,
  parameter int MAX_ERRORS  = 3,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] key_status,
  input  logic       door,
  input  logic       window,
  output logic       siren,
  output logic       armed,
  output logic       beep,
  output logic       locked,
  output logic [2:0] state,
  output logic [1:0] err_count
);

  localparam logic [1:0]       c_max_err  = 2'(MAX_ERRORS);
  localparam logic [CNT_W-1:0] c_exit_ld  = CNT_W'(EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] c_entry_ld = CNT_W'(ENTRY_CYC - 1);
  localparam logic [CNT_W-1:0] c_alarm_ld = CNT_W'(ALARM_CYC - 1);
  localparam logic [CNT_W-1:0] c_lock_ld  = CNT_W'(LOCKOUT_CYC - 1);

  logic             w_ok_ev;
  logic             w_err_ev;
  logic             r_door_s1, r_door_s2;
  logic             r_win_s1, r_win_s2;
  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [1:0]       r_err;
  logic [1:0]       w_err_nx;
  logic [1:0]       w_err_inc;
  logic             w_err_hit;
  logic             w_cnt_zero;
  logic             r_siren, r_armed, r_beep, r_locked;

  key_event_sync u_key_event_sync (
    .clk        (clk),
    .reset      (reset),
    .key_status (key_status),
    .ok_ev      (w_ok_ev),
    .err_ev     (w_err_ev)
  );

  assign w_cnt_zero = (r_cnt == '0);
  assign w_err_inc  = (r_err < c_max_err) ? r_err + 2'd1 : r_err;
  assign w_err_hit  = w_err_ev && (w_err_inc == c_max_err);

  // OK always has first say; sensors are checked before the error-limit path
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
    w_err_nx   = r_err;
    case (r_state)
      ST_DISARMED: begin
        if (w_ok_ev) begin
          w_state_nx = ST_EXIT_DELAY;
          w_cnt_nx   = c_exit_ld;
          w_err_nx   = '0;
        end else if (w_err_ev) begin
          w_err_nx = w_err_inc;
          if (w_err_hit) begin
            w_state_nx = ST_LOCKOUT;
            w_cnt_nx   = c_lock_ld;
          end
        end
      end
      ST_EXIT_DELAY: begin
        if (w_ok_ev) begin
          w_state_nx = ST_DISARMED;
          w_err_nx   = '0;
        end else begin
          if (w_err_ev) w_err_nx = w_err_inc;
          if (w_cnt_zero) w_state_nx = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_ok_ev) begin
          w_state_nx = ST_DISARMED;
          w_err_nx   = '0;
        end else begin
          if (w_err_ev) w_err_nx = w_err_inc;
          if (r_win_s2 || (!r_door_s2 && w_err_hit)) begin
            w_state_nx = ST_ALARM;
            w_cnt_nx   = c_alarm_ld;
          end else if (r_door_s2) begin
            w_state_nx = ST_ENTRY_DELAY;
            w_cnt_nx   = c_entry_ld;
          end
        end
      end
      ST_ENTRY_DELAY: begin
        if (w_ok_ev) begin
          w_state_nx = ST_DISARMED;
          w_err_nx   = '0;
        end else begin
          if (w_err_ev) w_err_nx = w_err_inc;
          if (r_win_s2 || w_cnt_zero || w_err_hit) begin
            w_state_nx = ST_ALARM;
            w_cnt_nx   = c_alarm_ld;
          end
        end
      end
      ST_ALARM: begin
        if (w_ok_ev) begin
          w_state_nx = ST_DISARMED;
          w_err_nx   = '0;
        end else if (w_cnt_zero) begin
          w_state_nx = ST_ARMED;
          w_err_nx   = '0;
        end else if (w_err_ev) begin
          w_err_nx = w_err_inc;
        end
      end
      ST_LOCKOUT: begin
        if (w_cnt_zero) begin
          w_state_nx = ST_DISARMED;
          w_err_nx   = '0;
        end
      end
      default: begin
        w_state_nx = ST_DISARMED;
        w_err_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_door_s1 <= 1'b0;
      r_door_s2 <= 1'b0;
      r_win_s1  <= 1'b0;
      r_win_s2  <= 1'b0;
      r_state   <= ST_DISARMED;
      r_cnt     <= '0;
      r_err     <= '0;
      r_siren   <= 1'b0;
      r_armed   <= 1'b0;
      r_beep    <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_door_s1 <= door;
      r_door_s2 <= r_door_s1;
      r_win_s1  <= window;
      r_win_s2  <= r_win_s1;
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_err     <= w_err_nx;
      // decoded from the next state so indicators change on the same edge as state
      r_siren   <= (w_state_nx == ST_ALARM);
      r_armed   <= (w_state_nx == ST_ARMED) || (w_state_nx == ST_ENTRY_DELAY);
      r_beep    <= (w_state_nx == ST_EXIT_DELAY) || (w_state_nx == ST_ENTRY_DELAY);
      r_locked  <= (w_state_nx == ST_LOCKOUT);
    end
  end

  assign siren     = r_siren;
  assign armed     = r_armed;
  assign beep      = r_beep;
  assign locked    = r_locked;
  assign state     = r_state;
  assign err_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller.sv
// ---------------------------------------------------------------
// tb_alarm_controller : directed scoreboard bench for alarm_controller
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] key_status;
  logic       door;
  logic       window;
  logic       siren, armed, beep, locked;
  logic [2:0] state;
  logic [1:0] err_count;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    int         due;
    logic [8:0] exp;
  } item_t;

  item_t      sb[$];
  item_t      mon_it;
  logic [8:0] mon_obs;
  int         b;

  alarm_controller dut (
    .clk        (clk),
    .reset      (reset),
    .key_status (key_status),
    .door       (door),
    .window     (window),
    .siren      (siren),
    .armed      (armed),
    .beep       (beep),
    .locked     (locked),
    .state      (state),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // expected outputs for a given state, packed as {state, siren, armed, beep, locked, err_count}
  task automatic exp_st(input string tag, input int due, input logic [2:0] st, input logic [1:0] err);
    item_t it;
    it.tag = tag;
    it.due = due;
    it.exp = {st, st == 3'd4, (st == 3'd2) || (st == 3'd3), (st == 3'd1) || (st == 3'd3), st == 3'd5, err};
    sb.push_back(it);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_it  = sb.pop_front();
      mon_obs = {state, siren, armed, beep, locked, err_count};
      n_checks++;
      assert (mon_it.due == cyc && mon_obs === mon_it.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b (due cycle %0d, now %0d)",
               mon_it.tag, mon_obs, mon_it.exp, mon_it.due, cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int due);
    while (cyc < due) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: observed %0d pending expectations, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    key_status = 2'd3;
    door       = 1'b0;
    window     = 1'b0;
    tick(3);
    exp_st("reset", cyc, 3'd0, 2'd0);
    drain(10);
    reset = 1'b0;
    tick(5);

    // arm: OK seen on 4th edge, exit delay lasts 8 cycles
    b = cyc;
    exp_st("t1_wait",     b + 3,  3'd0, 2'd0);
    exp_st("t1_exit",     b + 4,  3'd1, 2'd0);
    exp_st("t1_exit_end", b + 11, 3'd1, 2'd0);
    exp_st("t1_armed",    b + 12, 3'd2, 2'd0);
    key_status = 2'd0;
    wait_until(b + 5);
    key_status = 2'd3;
    drain(40);
    tick(5);

    // door -> entry delay -> alarm -> auto re-arm
    b = cyc;
    exp_st("t2_sync",      b + 2,  3'd2, 2'd0);
    exp_st("t2_entry",     b + 3,  3'd3, 2'd0);
    exp_st("t2_entry_end", b + 8,  3'd3, 2'd0);
    exp_st("t2_alarm",     b + 9,  3'd4, 2'd0);
    exp_st("t2_alarm_end", b + 18, 3'd4, 2'd0);
    exp_st("t2_rearm",     b + 19, 3'd2, 2'd0);
    door = 1'b1;
    wait_until(b + 3);
    door = 1'b0;
    drain(40);
    tick(5);

    // one error while armed, then window+door together, then OK disarms
    b = cyc;
    exp_st("t3_err1",       b + 4,  3'd2, 2'd1);
    exp_st("t3_window",     b + 11, 3'd4, 2'd1);
    exp_st("t3_alarm_hold", b + 15, 3'd4, 2'd1);
    exp_st("t3_ok",         b + 16, 3'd0, 2'd0);
    key_status = 2'd2;
    wait_until(b + 5);
    key_status = 2'd3;
    wait_until(b + 8);
    door   = 1'b1;
    window = 1'b1;
    wait_until(b + 9);
    door   = 1'b0;
    window = 1'b0;
    wait_until(b + 12);
    key_status = 2'd0;
    wait_until(b + 17);
    key_status = 2'd3;
    drain(40);
    tick(5);

    // three errors -> lockout, OK ignored, lockout lasts 12 cycles
    b = cyc;
    exp_st("t4_err1",      b + 4,  3'd0, 2'd1);
    exp_st("t4_err2",      b + 14, 3'd0, 2'd2);
    exp_st("t4_pre_lock",  b + 23, 3'd0, 2'd2);
    exp_st("t4_lock",      b + 24, 3'd5, 2'd3);
    exp_st("t4_ok_ignore", b + 32, 3'd5, 2'd3);
    exp_st("t4_lock_end",  b + 35, 3'd5, 2'd3);
    exp_st("t4_unlock",    b + 36, 3'd0, 2'd0);
    key_status = 2'd2;
    wait_until(b + 5);
    key_status = 2'd3;
    wait_until(b + 10);
    key_status = 2'd2;
    wait_until(b + 15);
    key_status = 2'd3;
    wait_until(b + 20);
    key_status = 2'd2;
    wait_until(b + 25);
    key_status = 2'd3;
    wait_until(b + 28);
    key_status = 2'd0;
    wait_until(b + 33);
    key_status = 2'd3;
    drain(60);
    tick(5);

    // OK arriving on the exit-delay expiry cycle cancels instead of arming
    b = cyc;
    exp_st("t5_exit",     b + 4,  3'd1, 2'd0);
    exp_st("t5_last",     b + 11, 3'd1, 2'd0);
    exp_st("t5_ok_wins",  b + 12, 3'd0, 2'd0);
    exp_st("t5_not_arm",  b + 13, 3'd0, 2'd0);
    key_status = 2'd0;
    wait_until(b + 3);
    key_status = 2'd3;
    wait_until(b + 8);
    key_status = 2'd0;
    wait_until(b + 13);
    key_status = 2'd3;
    drain(40);
    tick(5);

    // glitches filtered, then arm, alarm via window, reset mid-alarm
    b = cyc;
    exp_st("t6_err1",       b + 4,  3'd0, 2'd1);
    exp_st("t6_glitch1",    b + 15, 3'd0, 2'd1);
    exp_st("t6_glitch2",    b + 20, 3'd0, 2'd1);
    exp_st("t6_ok",         b + 21, 3'd1, 2'd0);
    exp_st("t6_exit_end",   b + 28, 3'd1, 2'd0);
    exp_st("t6_armed",      b + 29, 3'd2, 2'd0);
    exp_st("t6_alarm",      b + 33, 3'd4, 2'd0);
    exp_st("t6_alarm_hold", b + 35, 3'd4, 2'd0);
    exp_st("t6_reset",      b + 36, 3'd0, 2'd0);
    exp_st("t6_post_reset", b + 38, 3'd0, 2'd0);
    key_status = 2'd2;
    wait_until(b + 5);
    key_status = 2'd3;
    wait_until(b + 10);
    key_status = 2'd1;
    wait_until(b + 11);
    key_status = 2'd3;
    wait_until(b + 16);
    key_status = 2'd2;
    wait_until(b + 17);
    key_status = 2'd0;
    wait_until(b + 22);
    key_status = 2'd3;
    wait_until(b + 30);
    window = 1'b1;
    wait_until(b + 31);
    window = 1'b0;
    wait_until(b + 35);
    reset = 1'b1;
    wait_until(b + 37);
    reset = 1'b0;
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
Main home-alarm state machine, directly downstream of the key checker. Consumes the checker's 2-bit key status (OK=0, ERROR=2, NOKEY=3), which is asynchronous to the system clock. Also consumes door (delayed) and window (instant) sensor inputs. Drives siren, arming and status indicators, and enforces a lockout after repeated wrong codes.

Parameters:
EXIT_CYC, 8, cycles spent in EXIT_DELAY before arming
ENTRY_CYC, 6, cycles spent in ENTRY_DELAY before alarm
ALARM_CYC, 10, cycles siren stays on before auto re-arm
LOCKOUT_CYC, 12, cycles of keypad lockout
MAX_ERRORS, 3, consecutive ERROR results that trigger lockout or alarm (range 1..3)
CNT_W, 24, width of the shared down-counter (must hold the largest *_CYC)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key_status  in  2  key checker result, asynchronous; 0=OK, 2=ERROR, 3=NOKEY, 1=invalid
door  in  1  entry-zone sensor, active-high, asynchronous
window  in  1  instant-zone sensor, active-high, asynchronous
siren  out  1  high in ALARM
armed  out  1  high in ARMED or ENTRY_DELAY
beep  out  1  high in EXIT_DELAY or ENTRY_DELAY
locked  out  1  high in LOCKOUT
state  out  3  current state encoding
err_count  out  2  consecutive ERROR results, saturating at MAX_ERRORS

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=DISARMED; siren, armed, beep, locked = 0; err_count=0; counter=0; synchronizers=NOKEY / 0.
- All outputs are registered decodes of the state register.
- Key event filtering:
  - key_status passes through a 2-FF synchronizer and a third stage.
  - A value is "stable" when stages 2 and 3 are equal.
  - OK_EV / ERR_EV is a one-cycle pulse when the stable value becomes OK / ERROR and the previous stable value was NOKEY.
  - Value 1 and direct OK<->ERROR changes produce no event.
  - Glitches of a single sample (e.g. 11->10->00) are filtered out.
  - The state change is visible after the 4th rising edge following a settled key_status change.
- Sensors: 2-FF synchronized, level-sensitive, 2-cycle latency.
- States (encoding): DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4, LOCKOUT=5; codes 6 and 7 go to DISARMED.
- Timer:
  - Entering a timed state loads counter = X_CYC-1.
  - The counter decrements every cycle.
  - The state exits on the cycle where counter==0, so each timed state lasts exactly X_CYC cycles.
- Transitions:
  - DISARMED:
    - OK_EV -> EXIT_DELAY.
    - ERR_EV -> err_count+1; reaching MAX_ERRORS -> LOCKOUT.
    - Sensors are ignored.
  - EXIT_DELAY:
    - OK_EV -> DISARMED (cancel).
    - Timeout -> ARMED.
    - Sensors are ignored.
  - ARMED:
    - OK_EV -> DISARMED.
    - window -> ALARM.
    - door -> ENTRY_DELAY.
    - ERR_EV reaching MAX_ERRORS -> ALARM.
  - ENTRY_DELAY:
    - OK_EV -> DISARMED.
    - window -> ALARM.
    - Timeout -> ALARM.
    - ERR_EV reaching MAX_ERRORS -> ALARM.
  - ALARM:
    - OK_EV -> DISARMED.
    - Timeout -> ARMED.
    - ERR_EV counts but causes no transition.
  - LOCKOUT:
    - All key events are ignored.
    - Timeout -> DISARMED with err_count cleared.
- err_count rules:
  - Any OK_EV clears err_count.
  - Entering LOCKOUT or ALARM via errors leaves err_count at MAX_ERRORS.
  - Leaving ALARM by timeout clears err_count.
- Simultaneous-event priority:
  - OK_EV beats timer expiry and beats sensors.
  - window beats door.
  - ERR_EV and a sensor in the same cycle: the sensor transition wins, and err_count still increments.
- Reset mid-operation: any state returns to DISARMED on the next edge; the counter and the synchronizers are cleared.

Decomposition:
- Package alarm_pkg:
  - Key status constants KEY_OK=0, KEY_ERROR=2, KEY_NOKEY=3.
  - State enumeration and encodings listed above.
- Sub-module key_event_sync: 3-stage synchronizer, stability check and NOKEY->result edge detect; outputs ok_ev and err_ev.
- Sensor synchronizers and the FSM/timer stay in alarm_controller.

Test Plan:
1. Reset, then key_status 3->0 -> state=1 and beep=1 after the 4th edge; state=2 and armed=1 exactly 8 cycles later; beep=0.
2. Armed; door=1 for 3 cycles -> state=3 after 2 cycles; no key for 6 cycles -> state=4, siren=1; 10 cycles later state=2, siren=0.
3. Armed; door and window rise together -> state=4 directly; key 3->0 during ALARM -> state=0, siren=0, err_count=0.
4. DISARMED; three 3->2->3 sequences -> err_count 1,2,3, state=5, locked=1; a 3->0 during lockout is ignored; after 12 cycles state=0, err_count=0.
5. EXIT_DELAY with OK_EV arriving on the counter==0 cycle -> state=0 (OK wins), not 2.
6. Glitch: key_status 3->1 for one sample then 3, and a 3->2->0 with 2 held for only 1 cycle -> no ERROR event, err_count unchanged; reset asserted in ALARM -> state=0, all outputs 0 next edge.
